// File: rtl/pingpong_pkg.sv
// Shared bank-state encoding and sizing helper for the ping-pong buffer.
package pingpong_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'b00,
        BANK_FILLING = 2'b01,
        BANK_FULL    = 2'b10
    } bank_state_e;

    // Bits needed to hold a fill length in the range 0..depth.
    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pingpong_bank.sv
// One storage bank: synchronous write port and registered read port.
module pingpong_bank
    import pingpong_pkg::*;
#(
    parameter int WIDTH      = 80,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 120
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately unreset; the read register only moves on a read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pingpong_buffer.sv
// Double-banked fill/read buffer: one bank streams in while the other is read.
// Optional per-word even parity with rd_perr output when PINGPONG_PARITY_EN is defined.
module pingpong_buffer
    import pingpong_pkg::*;
#(
    parameter int DATA_WIDTH = 80,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 120
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  rd_bank_valid,
    output logic [ADDR_WIDTH:0]   rd_len,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_oob,
    input  logic                  rd_release,
    output logic [1:0]            bank_full
`ifdef PINGPONG_PARITY_EN
    ,
    output logic                  rd_perr
`endif
);

    localparam int LEN_W = len_width(DEPTH);
    localparam int RL_W  = ADDR_WIDTH + 1;
`ifdef PINGPONG_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int STORE_W = DATA_WIDTH + PAR_W;

    bank_state_e           state_q [2];
    bank_state_e           state_d [2];
    logic [LEN_W-1:0]      len_q   [2];
    logic [LEN_W-1:0]      len_d   [2];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  wbank_q, wbank_d;
    logic                  rbank_q, rbank_d;
    logic                  rd_hit_q, rd_sel_q, rd_oob_q;

    logic                  wr_fire, wr_done, rd_fire, rd_in_range, rel_fire;
    logic [STORE_W-1:0]    wr_word;
    logic [STORE_W-1:0]    bank_rdata [2];
    logic [STORE_W-1:0]    rd_word;

    // Reset gates ready so nothing is offered as accepted while rst_n is low.
    assign wr_ready = rst_n & ((state_q[wbank_q] == BANK_EMPTY) ||
                               (state_q[wbank_q] == BANK_FILLING));
    assign wr_fire  = wr_valid & wr_ready;
    assign wr_done  = wr_fire & (wr_last | (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)));

    assign rd_bank_valid = (state_q[rbank_q] == BANK_FULL);
    assign rd_len        = rd_bank_valid ? RL_W'(len_q[rbank_q]) : '0;
    assign rd_fire       = rd_en & rd_bank_valid;
    assign rd_in_range   = RL_W'(rd_addr) < RL_W'(len_q[rbank_q]);
    assign rel_fire      = rd_release & rd_bank_valid;

    assign bank_full = {state_q[1] == BANK_FULL, state_q[0] == BANK_FULL};

    // A write and a release never target the same bank: one needs it FULL, the other not.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        wbank_d  = wbank_q;
        rbank_d  = rbank_q;
        if (wr_fire) begin
            if (wr_done) begin
                state_d[wbank_q] = BANK_FULL;
                len_d[wbank_q]   = LEN_W'(wr_ptr_q) + LEN_W'(1);
                wr_ptr_d         = '0;
                wbank_d          = ~wbank_q;
            end else begin
                state_d[wbank_q] = BANK_FILLING;
                wr_ptr_d         = wr_ptr_q + ADDR_WIDTH'(1);
            end
        end
        if (rel_fire) begin
            state_d[rbank_q] = BANK_EMPTY;
            len_d[rbank_q]   = '0;
            rbank_d          = ~rbank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= '{default: BANK_EMPTY};
            len_q    <= '{default: '0};
            wr_ptr_q <= '0;
            wbank_q  <= 1'b0;
            rbank_q  <= 1'b0;
            rd_hit_q <= 1'b0;
            rd_sel_q <= 1'b0;
            rd_oob_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            wbank_q  <= wbank_d;
            rbank_q  <= rbank_d;
            // rd_hit_q/rd_sel_q only move on a serviced read so rd_data holds otherwise.
            if (rd_fire) begin
                rd_hit_q <= rd_in_range;
                rd_sel_q <= rbank_q;
                rd_oob_q <= ~rd_in_range;
            end else begin
                rd_oob_q <= 1'b0;
            end
        end
    end

`ifdef PINGPONG_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    pingpong_bank #(
        .WIDTH      (STORE_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank0 (
        .clk     (clk),
        .wr_en   (wr_fire & (wbank_q == 1'b0)),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_word),
        .rd_en   (rd_fire & rd_in_range & (rbank_q == 1'b0)),
        .rd_addr (rd_addr),
        .rd_data (bank_rdata[0])
    );

    pingpong_bank #(
        .WIDTH      (STORE_W),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank1 (
        .clk     (clk),
        .wr_en   (wr_fire & (wbank_q == 1'b1)),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_word),
        .rd_en   (rd_fire & rd_in_range & (rbank_q == 1'b1)),
        .rd_addr (rd_addr),
        .rd_data (bank_rdata[1])
    );

    assign rd_word = bank_rdata[rd_sel_q];
    assign rd_data = rd_hit_q ? rd_word[DATA_WIDTH-1:0] : '0;
    assign rd_oob  = rd_oob_q;

`ifdef PINGPONG_PARITY_EN
    // Stored word includes its even-parity bit, so any odd bit flip shows as 1.
    assign rd_perr = rd_hit_q & (^rd_word);
`endif

endmodule

// File: tb/tb_pingpong_buffer.sv
// Self-checking bench for pingpong_buffer (DATA_WIDTH=16, ADDR_WIDTH=3, DEPTH=8).
module tb_pingpong_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, wr_ready, wr_last;
    logic [15:0] wr_data;
    logic        rd_bank_valid;
    logic [3:0]  rd_len;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_oob;
    logic        rd_release;
    logic [1:0]  bank_full;
`ifdef PINGPONG_PARITY_EN
    logic        rd_perr;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] d;
        logic        oob;
        logic        perr;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] exp_d;
        logic        exp_oob;
    } rd_vec_t;
    rd_vec_t tbl [8];

    pingpong_buffer #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (3),
        .DEPTH      (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .rd_bank_valid (rd_bank_valid),
        .rd_len        (rd_len),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_oob        (rd_oob),
        .rd_release    (rd_release),
        .bank_full     (bank_full)
`ifdef PINGPONG_PARITY_EN
        ,
        .rd_perr       (rd_perr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word was offered/accepted.
    task automatic wr_word(input logic [15:0] d, input logic last);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: got wr_ready=0 expected 1 within 20 cycles");
        end
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic rd_pop();
        sb_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no expected entry required 1");
            return;
        end
        e = sb.pop_front();
        check("rd_data", 32'(rd_data), 32'(e.d));
        check("rd_oob", 32'(rd_oob), 32'(e.oob));
`ifdef PINGPONG_PARITY_EN
        check("rd_perr", 32'(rd_perr), 32'(e.perr));
`endif
    endtask

    task automatic rd_issue(input logic [2:0] a, input logic [15:0] ed, input logic eo,
                            input logic ep, input logic rel);
        rd_en      = 1'b1;
        rd_addr    = a;
        rd_release = rel;
        sb.push_back('{d: ed, oob: eo, perr: ep});
        @(negedge clk);
        rd_en      = 1'b0;
        rd_release = 1'b0;
        rd_pop();
    endtask

    initial begin
        tbl[0] = '{addr: 3'd2, exp_d: 16'h0A03, exp_oob: 1'b0};
        tbl[1] = '{addr: 3'd0, exp_d: 16'h0A01, exp_oob: 1'b0};
        tbl[2] = '{addr: 3'd4, exp_d: 16'h0A05, exp_oob: 1'b0};
        tbl[3] = '{addr: 3'd6, exp_d: 16'h0000, exp_oob: 1'b1};
        tbl[4] = '{addr: 3'd1, exp_d: 16'h0A02, exp_oob: 1'b0};
        tbl[5] = '{addr: 3'd5, exp_d: 16'h0000, exp_oob: 1'b1};
        tbl[6] = '{addr: 3'd3, exp_d: 16'h0A04, exp_oob: 1'b0};
        tbl[7] = '{addr: 3'd7, exp_d: 16'h0000, exp_oob: 1'b1};

        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_bank_full", 32'(bank_full), 32'd0);
        check("rst_rd_bank_valid", 32'(rd_bank_valid), 32'd0);
        check("rst_rd_len", 32'(rd_len), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_oob", 32'(rd_oob), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("wr_ready_after_rst", 32'(wr_ready), 32'd1);

        // First fill: five words, last flagged.
        for (int i = 1; i <= 5; i++) wr_word(16'h0A00 + 16'(i), i == 5);
        check("fill0_valid", 32'(rd_bank_valid), 32'd1);
        check("fill0_len", 32'(rd_len), 32'd5);
        check("fill0_bank_full", 32'(bank_full), 32'b01);
        check("fill0_wr_ready", 32'(wr_ready), 32'd1);

        for (int i = 0; i < 8; i++) rd_issue(tbl[i].addr, tbl[i].exp_d, tbl[i].exp_oob, 1'b0, 1'b0);

        // Out-of-range pulse lasts exactly one cycle.
        rd_issue(3'd6, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("oob_one_cycle", 32'(rd_oob), 32'd0);
        check("oob_data_held", 32'(rd_data), 32'd0);

        // Overlap: fill bank1 with DEPTH words, no wr_last, while bank0 is read.
        for (int i = 1; i <= 4; i++) wr_word(16'h0B00 + 16'(i), 1'b0);
        rd_issue(3'd1, 16'h0A02, 1'b0, 1'b0, 1'b0);
        for (int i = 5; i <= 8; i++) wr_word(16'h0B00 + 16'(i), 1'b0);
        check("auto_full_bank_full", 32'(bank_full), 32'b11);
        check("auto_full_wr_ready", 32'(wr_ready), 32'd0);
        check("auto_full_rd_len", 32'(rd_len), 32'd5);
        @(negedge clk);
        check("both_full_wr_ready_holds", 32'(wr_ready), 32'd0);

        // Read and release in the same cycle.
        rd_issue(3'd0, 16'h0A01, 1'b0, 1'b0, 1'b1);
        check("rel_valid", 32'(rd_bank_valid), 32'd1);
        check("rel_len", 32'(rd_len), 32'd8);
        check("rel_wr_ready", 32'(wr_ready), 32'd1);
        check("rel_bank_full", 32'(bank_full), 32'b10);
        rd_issue(3'd7, 16'h0B08, 1'b0, 1'b0, 1'b0);
        rd_issue(3'd0, 16'h0B01, 1'b0, 1'b0, 1'b0);

        // Final write into bank0 coincides with release of bank1.
        wr_word(16'h0C01, 1'b0);
        wr_valid = 1'b1; wr_data = 16'h0C02; wr_last = 1'b1; rd_release = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0; rd_release = 1'b0;
        check("swap_valid", 32'(rd_bank_valid), 32'd1);
        check("swap_len", 32'(rd_len), 32'd2);
        check("swap_wr_ready", 32'(wr_ready), 32'd1);
        check("swap_bank_full", 32'(bank_full), 32'b01);
        rd_issue(3'd1, 16'h0C02, 1'b0, 1'b0, 1'b0);

        // Release bank0, then ignored read and ignored release.
        rd_release = 1'b1;
        @(negedge clk);
        rd_release = 1'b0;
        check("empty_valid", 32'(rd_bank_valid), 32'd0);
        check("empty_len", 32'(rd_len), 32'd0);
        rd_en = 1'b1; rd_addr = 3'd0;
        @(negedge clk);
        rd_en = 1'b0;
        check("ignored_rd_data", 32'(rd_data), 32'h0C02);
        check("ignored_rd_oob", 32'(rd_oob), 32'd0);
        rd_release = 1'b1;
        @(negedge clk);
        rd_release = 1'b0;
        check("ignored_rel_bank_full", 32'(bank_full), 32'd0);
        check("ignored_rel_wr_ready", 32'(wr_ready), 32'd1);

        // Reset mid-fill discards the partial fill.
        for (int i = 1; i <= 3; i++) wr_word(16'h0D00 + 16'(i), 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_ready", 32'(wr_ready), 32'd0);
        check("midrst_bank_full", 32'(bank_full), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_word(16'h0E01, 1'b0);
        wr_word(16'h0E02, 1'b1);
        check("refill_len", 32'(rd_len), 32'd2);
        check("refill_bank_full", 32'(bank_full), 32'b01);
        rd_issue(3'd0, 16'h0E01, 1'b0, 1'b0, 1'b0);
        rd_issue(3'd1, 16'h0E02, 1'b0, 1'b0, 1'b0);

`ifdef PINGPONG_PARITY_EN
        dut.u_bank0.mem_q[1][0] = ~dut.u_bank0.mem_q[1][0];
        rd_issue(3'd1, 16'h0E03, 1'b0, 1'b1, 1'b0);
        rd_issue(3'd0, 16'h0E01, 1'b0, 1'b0, 1'b0);
        rd_issue(3'd5, 16'h0000, 1'b1, 1'b0, 1'b0);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000ns");
        $fatal(1);
    end

endmodule
